// File: rtl/prod_bcd_pkg.sv
// Shared constants and FSM encoding for the product binary-to-BCD converter.
package prod_bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DIGITS = 5;
  localparam int DEF_CNT_W  = 5;
  localparam int DIGIT_W    = 4;

endpackage

// File: rtl/product_bcd_conv_bcd_digit_adj.sv
// One double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import prod_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // add-3 correction so the following left shift carries correctly into the next digit
  always_comb begin
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/product_bcd_conv.sv
// Sequential shift-add-3 converter of the 16-bit multiplier product into packed BCD.
// Optional leading-zero mask output enabled by defining PROD_BCD_BLANK_EN.
module product_bcd_conv
  import prod_bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st,
  input  logic [WIDTH-1:0]         bin,
  output logic                     busy,
  output logic                     done,
  output logic [DIGIT_W*DIGITS-1:0] bcd
`ifdef PROD_BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]        blank
`endif
);

  localparam int ACC_W = DIGIT_W * DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e                 state_r;
  logic [WIDTH-1:0]       bin_sr_r;
  logic [ACC_W-1:0]       acc_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [ACC_W-1:0]       adj_s;
  logic [ACC_W+WIDTH-1:0] sh_s;
  logic [ACC_W-1:0]       acc_next_s;
  logic [WIDTH-1:0]       bin_next_s;
  logic                   last_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc_r[g*DIGIT_W +: DIGIT_W]),
      .dout (adj_s[g*DIGIT_W +: DIGIT_W])
    );
  end

  // corrected accumulator and binary register shift left together; bin MSB enters acc bit 0
  always_comb begin
    sh_s       = {adj_s, bin_sr_r} << 1'b1;
    acc_next_s = sh_s[ACC_W+WIDTH-1:WIDTH];
    bin_next_s = sh_s[WIDTH-1:0];
    last_s     = (state_r == SHIFT) && (cnt_r == LAST_CNT);
  end

  // conversion FSM: capture on start, one bit per clock, publish on the final shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      bin_sr_r <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (st) begin
            bin_sr_r <= bin;
            acc_r    <= '0;
            cnt_r    <= '0;
            busy     <= 1'b1;
            state_r  <= SHIFT;
          end
        end
        SHIFT: begin
          acc_r    <= acc_next_s;
          bin_sr_r <= bin_next_s;
          cnt_r    <= cnt_r + 1'b1;
          if (cnt_r == LAST_CNT) begin
            bcd     <= acc_next_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef PROD_BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  logic [DIGITS-1:0] blank_next_s;
  logic              zero_s;

  // digit i is blanked when it and every higher digit are zero; digit 0 always shown
  always_comb begin
    blank_next_s = '0;
    zero_s       = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_s          = zero_s & (acc_next_s[i*DIGIT_W +: DIGIT_W] == 4'd0);
      blank_next_s[i] = zero_s;
    end
  end

  // leading-zero mask registered at the same edge as bcd
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank <= BLANK_RST;
    end else if (last_s) begin
      blank <= blank_next_s;
    end
  end
`endif

endmodule

// File: tb/tb_product_bcd_conv.sv
// Directed self-checking bench for product_bcd_conv (default build; blank checked when enabled).
module tb_product_bcd_conv;

  logic        clk;
  logic        rst;
  logic        st;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
`ifdef PROD_BCD_BLANK_EN
  logic [4:0]  blank;
  logic [4:0]  cap_blank;
`endif

  int          passed_cnt;
  int          total_cnt;
  int          done_k;
  int          busy_n;
  int          done_n;
  int          last_k;
  logic [19:0] cap_bcd;
  logic [7:0]  ma;
  logic [7:0]  mb;
  logic [15:0] answer;

  product_bcd_conv dut (
    .clk  (clk),
    .rst  (rst),
    .st   (st),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .bcd  (bcd)
`ifdef PROD_BCD_BLANK_EN
    ,
    .blank(blank)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) passed_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // start one conversion at the next edge and watch 40 cycles; optional re-pulse at cycle ign
  task automatic run_conv(input logic [15:0] v, input int ign, input logic [15:0] alt);
    done_k = 0; busy_n = 0; done_n = 0; cap_bcd = '0;
    @(negedge clk);
    bin = v;
    st  = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) st = 1'b0;
      if (k == ign) begin
        st  = 1'b1;
        bin = alt;
      end
      if (k == ign + 1) st = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k == 0) begin
          done_k  = k;
          cap_bcd = bcd;
`ifdef PROD_BCD_BLANK_EN
          cap_blank = blank;
`endif
        end
      end
    end
  endtask

  initial begin
    passed_cnt = 0;
    total_cnt  = 0;
    rst = 1'b1; st = 1'b0; bin = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bcd", {12'd0, bcd}, 32'h00000);
`ifdef PROD_BCD_BLANK_EN
    check("rst_blank", {27'd0, blank}, 32'h1E);
`endif
    rst = 1'b0;

    run_conv(16'h0156, 0, 16'h0000);
    check("342_latency", done_k, 18 - 1);
    check("342_busy_width", busy_n, 16);
    check("342_done_count", done_n, 1);
    check("342_bcd", {12'd0, cap_bcd}, 32'h00342);
`ifdef PROD_BCD_BLANK_EN
    check("342_blank", {27'd0, cap_blank}, 32'h18);
`endif
    check("342_bcd_hold", {12'd0, bcd}, 32'h00342);

    run_conv(16'h0276, 0, 16'h0000);
    check("630_bcd", {12'd0, cap_bcd}, 32'h00630);
    check("630_latency", done_k, 17);

    run_conv(16'hFFFF, 0, 16'h0000);
    check("max_bcd", {12'd0, cap_bcd}, 32'h65535);
`ifdef PROD_BCD_BLANK_EN
    check("max_blank", {27'd0, cap_blank}, 32'h00);
`endif

    run_conv(16'h0000, 0, 16'h0000);
    check("zero_bcd", {12'd0, cap_bcd}, 32'h00000);
    check("zero_done", done_k, 17);
`ifdef PROD_BCD_BLANK_EN
    check("zero_blank", {27'd0, cap_blank}, 32'h1E);
`endif

    // restart attempt with a different bin at cycle 5 must be ignored
    run_conv(16'h0156, 5, 16'h0FFF);
    check("ign_bcd", {12'd0, cap_bcd}, 32'h00342);
    check("ign_done_count", done_n, 1);
    check("ign_busy_width", busy_n, 16);
    check("ign_latency", done_k, 17);

    // continuous start: a done every 17 cycles
    @(negedge clk);
    bin = 16'd999;
    st  = 1'b1;
    @(posedge clk);
    done_n = 0; last_k = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        done_n++;
        check("cont_bcd", {12'd0, bcd}, 32'h00999);
        check("cont_period", k - last_k, 17);
        last_k = k;
        if (done_n == 3) st = 1'b0;
      end
    end
    check("cont_done_count", done_n, 3);
    check("cont_idle_busy", {31'd0, busy}, 32'd0);

    // asynchronous reset after shift 8
    @(negedge clk);
    bin = 16'h0276;
    st  = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) st = 1'b0;
    end
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_bcd", {12'd0, bcd}, 32'h00000);
`ifdef PROD_BCD_BLANK_EN
    check("arst_blank", {27'd0, blank}, 32'h1E);
`endif
    @(negedge clk);
    rst = 1'b0;
    done_n = 0; busy_n = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done) done_n++;
      if (busy) busy_n++;
    end
    check("arst_no_done", done_n, 0);
    check("arst_no_busy", busy_n, 0);

    run_conv(16'h1234, 0, 16'h0000);
    check("1234_bcd", {12'd0, cap_bcd}, 32'h04660);
    check("1234_latency", done_k, 17);

    // multiplier product feeding bin after it settles
    ma = 8'h12;
    mb = 8'h13;
    answer = {8'h00, ma} * {8'h00, mb};
    run_conv(answer, 0, 16'h0000);
    check("mul_bcd", {12'd0, cap_bcd}, 32'h00342);

    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule
